// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode encodings and fetch byte-sequencer states.
package cpu_pkg;

  localparam int CPU_DATA_W  = 8;
  localparam int CPU_OP_W    = 3;
  localparam int CPU_ADDR_W  = 2 * CPU_DATA_W - CPU_OP_W;
  localparam int TRACE_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_LDA = 3'b001,
    OP_STA = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_AND = 3'b101,
    OP_JZ  = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic {
    BYTE_HI = 1'b0,
    BYTE_LO = 1'b1
  } byte_state_e;

endpackage

// File: rtl/fetch_trace_buf.sv
// 4-entry circular log of the PC at each instruction start; oldest entry overwritten.
// Write takes effect on the clock edge; read is combinational, count saturates at depth.
module fetch_trace_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [1:0]        sel,
  output logic [ADDR_W-1:0] rd_data,
  output logic [2:0]        cnt
);

  logic [ADDR_W-1:0] entry [TRACE_DEPTH];
  logic [1:0]        wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        entry[i] <= '0;
      end
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (wr_en) begin
      entry[wr_ptr] <= wr_data;
      wr_ptr        <= wr_ptr + 2'd1;
      if (cnt != 3'(TRACE_DEPTH)) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign rd_data = entry[sel];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: builds a 16-bit IR from two byte reads, holds the PC, drives the address mux.
// Fields registered one cycle after each strobe, no backpressure; FETCH_TRACE_EN adds a PC trace buffer.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = CPU_DATA_W,
  parameter  int OP_W     = CPU_OP_W,
  parameter  int RESET_PC = 0,
  localparam int ADDR_W   = 2 * DATA_W - OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_ir,
  input  logic              pc_inc,
  input  logic              load_pc,
  input  logic              fetch,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              ir_valid,
  input  logic [1:0]        trace_sel,
  output logic [ADDR_W-1:0] trace_pc,
  output logic [2:0]        trace_cnt
);

  localparam int IR_W = 2 * DATA_W;

  logic [IR_W-1:0]   ir;
  logic [ADDR_W-1:0] pc;
  byte_state_e       byte_state;
  logic              hi_capture;

  assign hi_capture = load_ir && (byte_state == BYTE_HI);

  // A gap in load_ir always drops back to HI so an abandoned fetch cannot misalign the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir         <= '0;
      ir_valid   <= 1'b0;
      byte_state <= BYTE_HI;
      pc         <= ADDR_W'(RESET_PC);
    end else begin
      if (load_ir) begin
        if (byte_state == BYTE_HI) begin
          ir[IR_W-1 -: DATA_W] <= data_in;
          ir_valid             <= 1'b0;
          byte_state           <= BYTE_LO;
        end else begin
          ir[DATA_W-1:0] <= data_in;
          ir_valid       <= 1'b1;
          byte_state     <= BYTE_HI;
        end
      end else begin
        byte_state <= BYTE_HI;
      end

      if (load_pc) begin
        pc <= ir[ADDR_W-1:0];
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
    end
  end

  assign opcode  = ir[IR_W-1 -: OP_W];
  assign ir_addr = ir[ADDR_W-1:0];
  assign pc_addr = pc;
  assign addr    = fetch ? pc : ir[ADDR_W-1:0];

`ifdef FETCH_TRACE_EN
  fetch_trace_buf #(
    .ADDR_W (ADDR_W)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (hi_capture),
    .wr_data (pc),
    .sel     (trace_sel),
    .rd_data (trace_pc),
    .cnt     (trace_cnt)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{trace_sel, hi_capture};
  assign trace_pc     = '0;
  assign trace_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, hand-written corner sequences, and random traffic vs a reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic        load_ir = 1'b0;
  logic        pc_inc = 1'b0;
  logic        load_pc = 1'b0;
  logic        fetch = 1'b1;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic [12:0] pc_addr;
  logic [12:0] addr;
  logic        ir_valid;
  logic [1:0]  trace_sel = '0;
  logic [12:0] trace_pc;
  logic [2:0]  trace_cnt;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load_ir   (load_ir),
    .pc_inc    (pc_inc),
    .load_pc   (load_pc),
    .fetch     (fetch),
    .opcode    (opcode),
    .ir_addr   (ir_addr),
    .pc_addr   (pc_addr),
    .addr      (addr),
    .ir_valid  (ir_valid),
    .trace_sel (trace_sel),
    .trace_pc  (trace_pc),
    .trace_cnt (trace_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: instruction word, PC, and length of the current run of load_ir cycles.
  int m_ir;
  int m_pc;
  int m_valid;
  int m_run;
  int hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ir = 0; m_pc = 0; m_valid = 0; m_run = 0;
    hist.delete();
  endtask

  function automatic int m_tcnt();
`ifdef FETCH_TRACE_EN
    return (hist.size() > 4) ? 4 : hist.size();
`else
    return 0;
`endif
  endfunction

  function automatic int m_tpc(input int sel);
`ifdef FETCH_TRACE_EN
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (k % 4 == sel) return hist[k];
    end
`endif
    return 0;
  endfunction

  task automatic model_clock(input logic li, input logic [7:0] d, input logic pi, input logic lp);
    int old_addr;
    int old_pc;
    old_addr = m_ir % 8192;
    old_pc   = m_pc;
    if (lp) m_pc = old_addr;
    else if (pi) m_pc = (m_pc + 1) % 8192;
    if (li) begin
      if (m_run % 2 == 0) begin
        m_ir = int'(d) * 256 + (m_ir % 256);
        m_valid = 0;
        hist.push_back(old_pc);
      end else begin
        m_ir = (m_ir / 256) * 256 + int'(d);
        m_valid = 1;
      end
      m_run++;
    end else begin
      m_run = 0;
    end
  endtask

  // One clock with the given strobes; returns 1 ns after the edge with strobes idle.
  task automatic cycle(input logic li, input logic [7:0] d, input logic pi, input logic lp);
    load_ir = li; data_in = d; pc_inc = pi; load_pc = lp;
    @(posedge clk);
    #1;
    load_ir = 1'b0; pc_inc = 1'b0; load_pc = 1'b0;
    model_clock(li, d, pi, lp);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".opcode"},   32'(opcode),   32'(m_ir / 8192));
    chk({tag, ".ir_addr"},  32'(ir_addr),  32'(m_ir % 8192));
    chk({tag, ".pc_addr"},  32'(pc_addr),  32'(m_pc));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
    chk({tag, ".trace_cnt"}, 32'(trace_cnt), 32'(m_tcnt()));
    chk({tag, ".trace_pc"}, 32'(trace_pc), 32'(m_tpc(int'(trace_sel))));
    fetch = 1'b1; #1;
    chk({tag, ".addr_pc"}, 32'(addr), 32'(m_pc));
    fetch = 1'b0; #1;
    chk({tag, ".addr_ir"}, 32'(addr), 32'(m_ir % 8192));
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.opcode",    32'(opcode),    32'(0));
    chk("rst.pc_addr",   32'(pc_addr),   32'(0));
    chk("rst.ir_valid",  32'(ir_valid),  32'(0));
    chk("rst.trace_cnt", 32'(trace_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        li;
    logic [7:0]  d;
    logic        pi;
    logic        lp;
    logic [2:0]  e_op;
    logic [12:0] e_ira;
    logic [12:0] e_pc;
    logic        e_vld;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // li  data   pi  lp   opcode  ir_addr   pc       valid
    vecs[0] = '{1'b1, 8'hA1, 1'b1, 1'b0, 3'b101, 13'h0100, 13'h0001, 1'b0};
    vecs[1] = '{1'b1, 8'h23, 1'b1, 1'b1, 3'b101, 13'h0123, 13'h0100, 1'b1};
    vecs[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'b111, 13'h1F23, 13'h0100, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'b111, 13'h1F23, 13'h0101, 1'b0};
    vecs[4] = '{1'b1, 8'h40, 1'b0, 1'b0, 3'b010, 13'h0023, 13'h0101, 1'b0};
    vecs[5] = '{1'b1, 8'h05, 1'b0, 1'b0, 3'b010, 13'h0005, 13'h0101, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'b010, 13'h0005, 13'h0005, 1'b1};

    do_reset();

    foreach (vecs[i]) begin
      cycle(vecs[i].li, vecs[i].d, vecs[i].pi, vecs[i].lp);
      chk($sformatf("vec%0d.opcode", i),   32'(opcode),   32'(vecs[i].e_op));
      chk($sformatf("vec%0d.ir_addr", i),  32'(ir_addr),  32'(vecs[i].e_ira));
      chk($sformatf("vec%0d.pc_addr", i),  32'(pc_addr),  32'(vecs[i].e_pc));
      chk($sformatf("vec%0d.ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_vld));
    end

    // PC wrap at the top of the address space, then load beating increment.
    cycle(1'b1, 8'h1F, 1'b0, 1'b0);
    cycle(1'b1, 8'hFE, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("wrap.start", 32'(pc_addr), 32'h1FFE);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap.1fff", 32'(pc_addr), 32'h1FFF);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap.0000", 32'(pc_addr), 32'h0000);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap.0001", 32'(pc_addr), 32'h0001);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h23, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("load_over_inc", 32'(pc_addr), 32'h0123);

    // Address mux follows fetch within the same cycle.
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    cycle(1'b1, 8'hBC, 1'b0, 1'b0);
    fetch = 1'b1; #1;
    chk("mux.pc", 32'(addr), 32'h0010);
    fetch = 1'b0; #1;
    chk("mux.ir", 32'(addr), 32'h0ABC);
    fetch = 1'b1; #1;
    chk("mux.pc_again", 32'(addr), 32'h0010);

    // Reset after only the high byte: the next two bytes must form a whole instruction.
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    chk("midrst.hi_valid", 32'(ir_valid), 32'(0));
    cycle(1'b1, 8'h23, 1'b0, 1'b0);
    chk("midrst.opcode",   32'(opcode),   32'(3'b101));
    chk("midrst.ir_addr",  32'(ir_addr),  32'h0123);
    chk("midrst.ir_valid", 32'(ir_valid), 32'(1));
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    chk("next_hi_drops_valid", 32'(ir_valid), 32'(0));

    // Five fetches starting at PCs 0,2,4,6,8.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
    end
`ifdef FETCH_TRACE_EN
    chk("trace.cnt", 32'(trace_cnt), 32'(4));
    for (int s = 0; s < 4; s++) begin
      trace_sel = 2'(s); #1;
      chk($sformatf("trace.sel%0d", s), 32'(trace_pc), (s == 0) ? 32'(8) : 32'(2 * s));
    end
`else
    chk("trace.cnt_off", 32'(trace_cnt), 32'(0));
    for (int s = 0; s < 4; s++) begin
      trace_sel = 2'(s); #1;
      chk($sformatf("trace.off_sel%0d", s), 32'(trace_pc), 32'(0));
    end
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end
      trace_sel = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch datapath that sits directly downstream of the CPU control sequencer.
- Consumes the sequencer's pc_inc, load_ir and load_pc strobes.
- Assembles the 16-bit instruction from two 8-bit memory reads, holds the program counter, and drives the memory address mux.
- Returns the opcode field to the sequencer's operation input.

Parameters:
- DATA_W, 8, memory data bus width; instruction is 2*DATA_W bits.
- OP_W, 3, opcode field width; localparam ADDR_W = 2*DATA_W - OP_W (13).
- RESET_PC, 0, program counter value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  memory read data.
- load_ir  in  1  capture data_in into the next IR byte.
- pc_inc  in  1  increment the PC.
- load_pc  in  1  load the PC from the IR address field.
- fetch  in  1  address select: 1 = PC, 0 = IR operand address.
- opcode  out  OP_W  IR[15:13], feeds the sequencer operation input.
- ir_addr  out  ADDR_W  IR[12:0].
- pc_addr  out  ADDR_W  current PC.
- addr  out  ADDR_W  memory address (fetch ? pc_addr : ir_addr), combinational.
- ir_valid  out  1  full instruction assembled.
- trace_sel  in  2  trace buffer read index.
- trace_pc  out  ADDR_W  trace entry at trace_sel.
- trace_cnt  out  3  number of valid trace entries.

Behaviour:
- Reset (async, rst_n low):
  - IR = 0, so opcode = HLT (3'b000) and ir_addr = 0.
  - pc_addr = RESET_PC; ir_valid = 0; byte sequencer = HI.
  - Trace buffer cleared; trace_cnt = 0.
  - Reset mid-fetch abandons the partial instruction.
- Byte sequencer, two states HI and LO:
  - HI with load_ir=1: IR[15:8] <= data_in, ir_valid <= 0, go to LO.
  - LO with load_ir=1: IR[7:0] <= data_in, ir_valid <= 1, go to HI.
  - load_ir=0 in any state: return to HI, IR held, ir_valid held. This resynchronises after an abandoned fetch.
  - A third consecutive load_ir cycle starts a new instruction (HI capture).
- Latency: opcode, ir_addr and ir_valid update one cycle after the LO capture edge. The high-byte fields (opcode, ir_addr[12:8]) are visible one cycle after the HI edge.
- PC:
  - load_pc=1: pc <= ir_addr, using the pre-edge IR value.
  - else pc_inc=1: pc <= pc + 1 modulo 2^ADDR_W; 0x1FFF wraps to 0x0000.
  - else pc holds.
- Simultaneous events:
  - load_pc with pc_inc: load wins.
  - load_pc with an LO capture: the PC takes the old ir_addr.
  - pc_inc with load_ir is legal and independent.
- addr is combinational; no registered state depends on fetch.
- No handshake back to the sequencer; the strobes are trusted one cycle each.

Optional Feature:
- Macro FETCH_TRACE_EN.
- Defined:
  - 4-entry circular buffer; on every HI capture, the current pc_addr is written at the write pointer.
  - Write pointer wraps 3 -> 0; the oldest entry is overwritten.
  - trace_cnt saturates at 4.
  - trace_pc = entry[trace_sel], combinational read.
- Undefined: ports remain; trace_pc = 0 and trace_cnt = 0 constantly; no trace storage is inferred.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants HLT..JMP (3'b000..3'b111);
  - DATA_W, OP_W and ADDR_W defaults;
  - byte-sequencer state encodings.
- One sub-module: fetch_trace_buf (4-entry circular buffer), instantiated only under FETCH_TRACE_EN.

Test Plan:
- Reset then release:
  - opcode=0, pc_addr=0, ir_valid=0, trace_cnt=0.
  - Drive rst_n low mid-fetch after the HI byte; sequencer returns to HI and ir_valid=0.
- load_ir two cycles, data 8'hA1 then 8'h23:
  - opcode=3'b101, ir_addr=13'h0123, ir_valid=1 one cycle after the second edge.
  - ir_valid drops at the next HI capture.
- load_ir one cycle (8'hFF), idle one cycle, then two cycles (8'h40, 8'h05):
  - Partial fetch discarded; final opcode=3'b010, ir_addr=13'h0005.
- PC at 13'h1FFE, pc_inc for 3 cycles:
  - pc_addr goes 1FFF, 0000, 0001.
  - load_pc and pc_inc together with ir_addr=13'h0123: pc_addr=13'h0123.
- fetch toggled with pc=13'h0010, ir_addr=13'h0ABC: addr follows in the same cycle, 0010 / 0ABC.
- FETCH_TRACE_EN, five fetches starting at PCs 0, 2, 4, 6, 8:
  - trace_cnt=4.
  - Entries read via trace_sel 0..3 = 8, 2, 4, 6 (slot 0 overwritten).
